// File: rtl/border_detect_stream_if.sv
// Pixel stream bundle for border_detect_stream.
// Carries the upstream pixel handshake (in_*), the per-frame configuration
// sampled on the start-of-frame pixel (thresh, mode) and the downstream
// classified-pixel handshake (out_*).
//   master : the environment side (drives input pixels and out_ready)
//   slave  : the border detector (drives in_ready and the out_* pixel)
interface border_detect_stream_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_pixel;
  logic              in_sof;
  logic [DATA_W-1:0] thresh;
  logic [1:0]        mode;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_pixel;
  logic              out_sof;
  logic              out_eof;

  modport master (
    output in_valid, in_pixel, in_sof, thresh, mode, out_ready,
    input  in_ready, out_valid, out_pixel, out_sof, out_eof
  );

  modport slave (
    input  in_valid, in_pixel, in_sof, thresh, mode, out_ready,
    output in_ready, out_valid, out_pixel, out_sof, out_eof
  );
endinterface

// File: rtl/border_detect_stream.sv
// Streaming 3x3 threshold border detector.
// Takes one raster-order pixel per accepted handshake and produces one
// classified pixel per input pixel, delayed by WIDTH+1 accepted pixels plus
// one cycle. After the last input pixel of a frame the block stops accepting
// and flushes the remaining WIDTH+1 outputs on its own.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - slave side of border_detect_stream_if:
//          in_valid/in_ready/in_pixel/in_sof  upstream pixel stream
//          thresh/mode                        sampled on the accepted sof pixel
//          out_valid/out_ready/out_pixel      classified pixel stream
//          out_sof/out_eof                    frame markers on first/last output
// Modes: 0 inner border, 1 outer border, 2 inner binary, 3 passthrough.
module border_detect_stream #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int DATA_W = 8
) (
  input logic clk,
  input logic rst,
  border_detect_stream_if.slave bus
);

  // The delay line holds the 2*WIDTH+2 pixels preceding the newest one,
  // i.e. two full lines plus the 3x3 window tail. With the newest pixel at
  // index k, the window centre (output index j = k-WIDTH-1) sits at tap WIDTH.
  localparam int TAPS  = 2 * WIDTH + 2;
  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int IDX_W = $clog2(TOTAL + 1);
  localparam int COL_W = $clog2(WIDTH);
  localparam int ROW_W = $clog2(HEIGHT);

  localparam logic [IDX_W-1:0] FIRST_OUT_IDX = IDX_W'(WIDTH + 1);
  localparam logic [IDX_W-1:0] LAST_IN_IDX   = IDX_W'(TOTAL - 1);
  localparam logic [COL_W-1:0] LAST_COL      = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW      = ROW_W'(HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  in_cnt;
  logic [ROW_W-1:0]  row_p0;
  logic [COL_W-1:0]  col_p0;
  logic [DATA_W-1:0] thresh_q;
  logic [1:0]        mode_q;

  logic [DATA_W-1:0] line_p0 [TAPS];

  logic              vld_p1;
  logic              sof_p1;
  logic              eof_p1;
  logic [DATA_W-1:0] pix_p1;

  logic                   reg_free;
  logic                   accept;
  logic                   emit;
  logic                   sof_hit;
  logic                   produce;
  logic                   flush_load;
  logic                   shift_en;
  logic                   is_border;
  logic                   first_out;
  logic                   last_out;
  logic [DATA_W-1:0]      newest;
  logic [DATA_W-1:0]      centre;
  logic [7:0][DATA_W-1:0] neigh;
  logic [DATA_W-1:0]      result;

  // Classify one window. Border pixels are forced to zero except in
  // passthrough; a neighbour equal to the threshold counts as neither
  // darker nor brighter, and a centre equal to it never qualifies.
  function automatic logic [DATA_W-1:0] classify(
    input logic [1:0]             m,
    input logic [DATA_W-1:0]      t,
    input logic                   border,
    input logic [DATA_W-1:0]      c,
    input logic [7:0][DATA_W-1:0] n
  );
    logic              lo;
    logic              hi;
    logic [DATA_W-1:0] r;
    lo = 1'b0;
    hi = 1'b0;
    for (int i = 0; i < 8; i++) begin
      lo = lo | (n[i] < t);
      hi = hi | (n[i] > t);
    end
    r = '0;
    case (m)
      2'd0:    if (!border && (c > t) && lo) r = c;
      2'd1:    if (!border && (c < t) && hi) r = c;
      2'd2:    if (!border && (c > t) && lo) r = '1;
      default: r = c;
    endcase
    return r;
  endfunction

  assign reg_free     = !vld_p1 || bus.out_ready;
  assign bus.in_ready = !rst && reg_free && (state != FLUSH);
  assign accept       = bus.in_valid && bus.in_ready;
  assign emit         = vld_p1 && bus.out_ready;
  assign sof_hit      = accept && bus.in_sof;

  // An output is produced for every accepted pixel from index WIDTH+1 on.
  assign produce = accept && !bus.in_sof &&
                   ((state == RUN) || ((state == FILL) && (in_cnt == FIRST_OUT_IDX)));

  // During flush a new output is loaded whenever the register is free,
  // until the frame's last pixel is sitting in it.
  assign flush_load = (state == FLUSH) && reg_free && !(vld_p1 && eof_p1);

  // Flush keeps shifting zeros in so the centre stays at the same tap.
  assign newest   = (state == FLUSH) ? '0 : bus.in_pixel;
  assign shift_en = accept || flush_load;

  assign is_border = (row_p0 == '0) || (row_p0 == LAST_ROW) ||
                     (col_p0 == '0) || (col_p0 == LAST_COL);
  assign first_out = (row_p0 == '0) && (col_p0 == '0);
  assign last_out  = (row_p0 == LAST_ROW) && (col_p0 == LAST_COL);

  always_comb begin
    centre   = line_p0[WIDTH];
    neigh[0] = line_p0[2*WIDTH+1];
    neigh[1] = line_p0[2*WIDTH];
    neigh[2] = line_p0[2*WIDTH-1];
    neigh[3] = line_p0[WIDTH+1];
    neigh[4] = line_p0[WIDTH-1];
    neigh[5] = line_p0[1];
    neigh[6] = line_p0[0];
    neigh[7] = newest;
  end

  assign result = classify(mode_q, thresh_q, is_border, centre, neigh);

  // Stage p0: two-line delay line feeding the 3x3 window
  always_ff @(posedge clk) begin
    if (shift_en) begin
      line_p0[0] <= newest;
      for (int i = 1; i < TAPS; i++) begin
        line_p0[i] <= line_p0[i-1];
      end
    end
  end

  // Stage p1: output register, frame control and output position counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      in_cnt   <= '0;
      row_p0   <= '0;
      col_p0   <= '0;
      thresh_q <= '0;
      mode_q   <= '0;
      vld_p1   <= 1'b0;
      sof_p1   <= 1'b0;
      eof_p1   <= 1'b0;
      pix_p1   <= '0;
    end else if (sof_hit) begin
      // Start of a new frame; any frame in progress is abandoned together
      // with whatever output was still waiting in the register.
      state    <= FILL;
      in_cnt   <= IDX_W'(1);
      row_p0   <= '0;
      col_p0   <= '0;
      thresh_q <= bus.thresh;
      mode_q   <= bus.mode;
      vld_p1   <= 1'b0;
      sof_p1   <= 1'b0;
      eof_p1   <= 1'b0;
    end else begin
      if (produce || flush_load) begin
        vld_p1 <= 1'b1;
        pix_p1 <= result;
        sof_p1 <= first_out;
        eof_p1 <= last_out;
        if (col_p0 == LAST_COL) begin
          col_p0 <= '0;
          row_p0 <= last_out ? '0 : row_p0 + 1'b1;
        end else begin
          col_p0 <= col_p0 + 1'b1;
        end
      end else if (emit) begin
        vld_p1 <= 1'b0;
        sof_p1 <= 1'b0;
        eof_p1 <= 1'b0;
      end

      case (state)
        FILL: begin
          if (accept) begin
            in_cnt <= in_cnt + 1'b1;
            if (in_cnt == FIRST_OUT_IDX) state <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            if (in_cnt == LAST_IN_IDX) begin
              in_cnt <= '0;
              state  <= FLUSH;
            end else begin
              in_cnt <= in_cnt + 1'b1;
            end
          end
        end
        FLUSH: begin
          if (emit && eof_p1) state <= IDLE;
        end
        default: ;
      endcase
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.out_pixel = pix_p1;
  assign bus.out_sof   = sof_p1;
  assign bus.out_eof   = eof_p1;

endmodule

// File: tb/tb_border_detect_stream.sv
// Testbench for border_detect_stream (WIDTH=8, HEIGHT=6, DATA_W=8).
// Frames are built as 2-D images, pushed through the block with optional
// random valid gaps and random downstream stalls, and the emitted stream is
// compared with a frame-level reference model of the classification rules.
module tb_border_detect_stream;

  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;

  logic clk;
  logic rst;

  border_detect_stream_if #(.DATA_W(8)) bus();

  border_detect_stream #(.WIDTH(W), .HEIGHT(H), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] img  [H][W];
  logic [7:0] expv [N];

  logic [7:0] q_pix [$];
  bit         q_sof [$];
  logic [7:0] q_thr [$];
  logic [1:0] q_mode[$];

  logic [7:0] got_pix [$];
  bit         got_sof [$];
  bit         got_eof [$];

  int cyc;
  int t10;
  int tsof;
  int acc_frame;
  bit sof_out_seen;
  int stall_err;
  int flush_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: apply the classification rules to the whole image.
  task automatic model(input logic [7:0] t, input logic [1:0] m);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        logic       lo;
        logic       hi;
        logic [7:0] cv;
        logic [7:0] o;
        cv = img[r][c];
        lo = 1'b0;
        hi = 1'b0;
        o  = 8'd0;
        if (m == 2'd3) begin
          o = cv;
        end else if (r != 0 && r != H-1 && c != 0 && c != W-1) begin
          for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
              if (dr != 0 || dc != 0) begin
                if (img[r+dr][c+dc] < t) lo = 1'b1;
                if (img[r+dr][c+dc] > t) hi = 1'b1;
              end
            end
          end
          case (m)
            2'd0:    o = (cv > t && lo) ? cv : 8'd0;
            2'd1:    o = (cv < t && hi) ? cv : 8'd0;
            default: o = (cv > t && lo) ? 8'hFF : 8'd0;
          endcase
        end
        expv[r*W+c] = o;
      end
    end
  endtask

  task automatic fill_img(input logic [7:0] bg, input logic [7:0] dot);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = bg;
    img[3][3] = dot;
  endtask

  task automatic rand_img();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = 8'($urandom);
  endtask

  task automatic clear_all();
    q_pix.delete(); q_sof.delete(); q_thr.delete(); q_mode.delete();
    got_pix.delete(); got_sof.delete(); got_eof.delete();
    t10 = -100; tsof = -200; acc_frame = 0; sof_out_seen = 1'b0;
    stall_err = 0; flush_err = 0;
  endtask

  task automatic push_junk(input int n);
    for (int i = 0; i < n; i++) begin
      q_pix.push_back(8'($urandom)); q_sof.push_back(1'b0);
      q_thr.push_back(8'($urandom)); q_mode.push_back(2'($urandom));
    end
  endtask

  task automatic push_frame(input int n, input logic [7:0] t, input logic [1:0] m);
    for (int i = 0; i < n; i++) begin
      q_pix.push_back(img[i/W][i%W]);
      q_sof.push_back(i == 0);
      q_thr.push_back(i == 0 ? t : 8'($urandom));
      q_mode.push_back(i == 0 ? m : 2'($urandom));
    end
  endtask

  // Drive the queued input stream, collect emitted outputs. Returns when an
  // eof pixel is emitted, when stop_acc pixels have been accepted (if >0),
  // or when the cycle budget expires.
  task automatic drive(input int vprob, input int rprob, input int stop_acc, output bit timed_out);
    int         pos;
    int         accn;
    bit         done;
    bit         all_in;
    bit         pv;
    bit         pr;
    logic [7:0] pp;
    bit         ps;
    bit         pe;
    pos = 0; accn = 0; done = 1'b0; pv = 1'b0; pr = 1'b0;
    pp = 8'd0; ps = 1'b0; pe = 1'b0;
    for (int n = 0; n < 5000 && !done; n++) begin
      @(negedge clk);
      cyc++;
      if (pos < q_pix.size() && int'($urandom_range(99)) < vprob) begin
        bus.in_valid = 1'b1;
        bus.in_pixel = q_pix[pos];
        bus.in_sof   = q_sof[pos];
        bus.thresh   = q_thr[pos];
        bus.mode     = q_mode[pos];
      end else begin
        bus.in_valid = 1'b0;
        bus.in_pixel = 8'($urandom);
        bus.in_sof   = 1'($urandom);
        bus.thresh   = 8'($urandom);
        bus.mode     = 2'($urandom);
      end
      bus.out_ready = int'($urandom_range(99)) < rprob;
      #1;
      all_in = (pos == q_pix.size());
      if (pv && !pr) begin
        if (bus.out_valid !== 1'b1 || bus.out_pixel !== pp ||
            bus.out_sof !== ps || bus.out_eof !== pe) stall_err++;
      end
      if (all_in && stop_acc == 0 && bus.in_ready !== 1'b0) flush_err++;
      if (bus.out_valid === 1'b1 && bus.out_sof === 1'b1 && !sof_out_seen) begin
        tsof = cyc;
        sof_out_seen = 1'b1;
      end
      if (bus.in_valid && bus.in_ready === 1'b1) begin
        if (bus.in_sof) begin
          acc_frame = 0;
          sof_out_seen = 1'b0;
        end
        acc_frame++;
        if (acc_frame == 10) t10 = cyc;
        pos++;
        accn++;
        if (stop_acc > 0 && accn >= stop_acc) done = 1'b1;
      end
      if (bus.out_valid === 1'b1 && bus.out_ready) begin
        got_pix.push_back(bus.out_pixel);
        got_sof.push_back(bus.out_sof);
        got_eof.push_back(bus.out_eof);
        if (bus.out_eof === 1'b1) done = 1'b1;
      end
      pv = (bus.out_valid === 1'b1); pr = bus.out_ready;
      pp = bus.out_pixel; ps = bus.out_sof; pe = bus.out_eof;
    end
    timed_out = !done;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  // Compare the last frame in the collected output against expv.
  task automatic check_frame(input string tag, input bit to, input bit whole);
    int start;
    int n;
    int mism;
    int first_bad;
    int eofs;
    start = -1; mism = 0; first_bad = -1; eofs = 0;
    for (int i = 0; i < got_sof.size(); i++) if (got_sof[i]) start = i;
    for (int i = 0; i < got_eof.size(); i++) if (got_eof[i]) eofs++;
    n = (start < 0) ? 0 : got_pix.size() - start;
    chk({tag, " timeout"}, 32'(to), 32'd0);
    chk({tag, " out count"}, n, N);
    if (whole) chk({tag, " sof position"}, start, 0);
    for (int k = 0; k < N && k < n; k++) begin
      if (got_pix[start+k] !== expv[k]) begin
        mism++;
        if (first_bad < 0) first_bad = k;
      end
    end
    if (mism != 0)
      $display("%s: first differing index %0d got %0d want %0d", tag, first_bad,
               got_pix[start+first_bad], expv[first_bad]);
    chk({tag, " pixel mismatches"}, mism, 0);
    chk({tag, " eof count"}, eofs, 1);
    chk({tag, " eof on last"}, (got_eof.size() > 0) ? 32'(got_eof[got_eof.size()-1]) : 32'd0, 32'd1);
    chk({tag, " sof latency"}, tsof - t10, 1);
    chk({tag, " stall stability"}, stall_err, 0);
    chk({tag, " flush in_ready"}, flush_err, 0);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] t, input logic [1:0] m,
                           input int vprob, input int rprob, input int junk);
    bit to;
    clear_all();
    push_junk(junk);
    push_frame(N, t, m);
    model(t, m);
    drive(vprob, rprob, 0, to);
    check_frame(tag, to, 1'b1);
  endtask

  initial begin
    bit to;
    int pre;
    int pre_eof;
    cyc = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_pixel = 8'd0; bus.in_sof = 1'b0;
    bus.thresh = 8'd0; bus.mode = 2'd0; bus.out_ready = 1'b1;
    clear_all();

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst out_valid", bus.out_valid, 0);
    chk("rst out_pixel", bus.out_pixel, 0);
    chk("rst out_sof", bus.out_sof, 0);
    chk("rst out_eof", bus.out_eof, 0);
    chk("rst in_ready", bus.in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle in_ready", bus.in_ready, 1);

    // Uniform frame: nothing is darker than the threshold
    fill_img(8'd255, 8'd255);
    run_frame("uniform m0", 8'd230, 2'd0, 100, 100, 0);

    // Dark dot in bright background
    fill_img(8'd255, 8'd10);
    run_frame("dot m0", 8'd128, 2'd0, 100, 100, 0);
    run_frame("dot m2", 8'd128, 2'd2, 100, 100, 0);
    run_frame("dot m1", 8'd128, 2'd1, 100, 100, 0);

    // Values equal to the threshold never qualify
    fill_img(8'd255, 8'd230);
    run_frame("eq m0", 8'd230, 2'd0, 100, 100, 0);
    run_frame("eq m1", 8'd230, 2'd1, 100, 100, 0);
    fill_img(8'd231, 8'd229);
    run_frame("near m0", 8'd230, 2'd0, 100, 100, 0);

    // Passthrough with gaps, stalls and junk before the sof pixel
    rand_img();
    run_frame("pass m3", 8'($urandom), 2'd3, 60, 50, 3);

    // Random content under random handshaking
    for (int f = 0; f < 3; f++) begin
      rand_img();
      run_frame($sformatf("rand m%0d", f), 8'($urandom_range(40, 215)), 2'(f), 70, 60, 0);
    end

    // Abort after 20 pixels, then a full frame with different settings
    clear_all();
    fill_img(8'd255, 8'd10);
    push_frame(20, 8'd5, 2'd1);
    push_frame(N, 8'd100, 2'd0);
    model(8'd100, 2'd0);
    drive(100, 100, 0, to);
    check_frame("abort", to, 1'b0);
    pre = 0; pre_eof = 0;
    for (int i = 0; i < got_sof.size(); i++) if (got_sof[i]) pre = i;
    for (int i = 0; i < pre; i++) if (got_eof[i]) pre_eof++;
    chk("abort prefix bound", 32'(pre <= 11), 32'd1);
    chk("abort prefix eof", pre_eof, 0);

    // Reset in the middle of RUN
    clear_all();
    rand_img();
    push_frame(N, 8'd128, 2'd2);
    drive(100, 100, 25, to);
    chk("midrst reached", 32'(to), 32'd0);
    #1;
    chk("midrst pre out_valid", bus.out_valid, 1);
    rst = 1'b1;
    #1;
    chk("midrst in_ready low", bus.in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst out_valid", bus.out_valid, 0);
    chk("midrst in_ready", bus.in_ready, 1);
    rand_img();
    run_frame("after rst m2", 8'd128, 2'd2, 80, 70, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
